// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encodings and parity modes.
package fifo_uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    FETCH  = ST_FETCH,
    LOAD   = ST_LOAD,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the synchronous FIFO and the UART transmitter.
// Handshake: the reader pulses fifoRead for one cycle only while fifoEmpty is low;
// fifoData then holds the popped word from the following cycle on.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  fifoEmpty;
  logic [DATA_WIDTH-1:0] fifoData;
  logic                  fifoRead;

  modport master (
    output fifoRead,
    input  fifoEmpty,
    input  fifoData
  );

  modport slave (
    input  fifoRead,
    output fifoEmpty,
    output fifoData
  );

endinterface

// File: rtl/fifo_uart_tx_baud.sv
// Bit-time generator: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bitDone
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear || count == TERM) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bitDone = (count == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the FIFO read port one word at a time and shifts each word out as a UART frame
// (start, data LSB first, optional parity, 1 or 2 stop bits).
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  fifo_uart_tx_if.master      fifo,
  output logic                tx,
  output logic                busy,
  output logic [15:0]         framesSent,
  output logic [2:0]          debugState
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD_FLIP  = (PARITY_MODE == PARITY_ODD);

  state_t                state;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic                  parityBit;
  logic [BW-1:0]         bitCnt;
  logic                  bitDone;
  logic                  baudClear;
  logic                  canFetch;

  assign canFetch = enable && !fifo.fifoEmpty;

  // Bit-timed states only leave on the terminal count, where the counter wraps to zero
  // anyway, so clearing it in the untimed states is enough to restart it on every change.
  assign baudClear = (state == IDLE) || (state == FETCH) || (state == LOAD);

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (baudClear),
    .bitDone(bitDone)
  );

  // tx is loaded with the value belonging to the state being entered, so the line
  // changes in the first cycle of that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      framesSent <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      parityBit  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (canFetch) state <= FETCH;
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          shiftReg  <= fifo.fifoData;
          parityBit <= (^fifo.fifoData) ^ ODD_FLIP;
          bitCnt    <= '0;
          tx        <= 1'b0;
          state     <= START;
        end
        START: begin
          if (bitDone) begin
            tx    <= shiftReg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bitDone) begin
            if (bitCnt == LAST_BIT) begin
              bitCnt <= '0;
              if (PARITY_MODE != PARITY_NONE) begin
                tx    <= parityBit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bitCnt   <= bitCnt + 1'b1;
              shiftReg <= shiftReg >> 1;
              tx       <= shiftReg[1];
            end
          end
        end
        PARITY: begin
          if (bitDone) begin
            bitCnt <= '0;
            tx     <= 1'b1;
            state  <= STOP;
          end
        end
        STOP: begin
          if (bitDone) begin
            if (bitCnt == LAST_STOP) begin
              bitCnt     <= '0;
              framesSent <= framesSent + 16'd1;
              state      <= canFetch ? FETCH : IDLE;
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign fifo.fifoRead = (state == FETCH);
  assign busy          = (state != IDLE);
  assign debugState    = state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one DUT without parity fed by a small FIFO model,
// plus even/2-stop and odd/1-stop instances sending a single 0x07 word.
module tb_fifo_uart_tx;
  import fifo_uart_tx_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic pArm = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] expFrames = 16'd0;

  fifo_uart_tx_if #(.DATA_WIDTH(8)) ifc ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) ifE ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) ifO ();

  logic txM, busyM, txE, busyE, txO, busyO;
  logic [15:0] fsM, fsE, fsO;
  logic [2:0] dsM, dsE, dsO;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1)) dut (
    .clk(clk), .reset(rst), .enable(enable), .fifo(ifc),
    .tx(txM), .busy(busyM), .framesSent(fsM), .debugState(dsM));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(2)) dut_even (
    .clk(clk), .reset(rst), .enable(enable), .fifo(ifE),
    .tx(txE), .busy(busyE), .framesSent(fsE), .debugState(dsE));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1)) dut_odd (
    .clk(clk), .reset(rst), .enable(enable), .fifo(ifO),
    .tx(txO), .busy(busyO), .framesSent(fsO), .debugState(dsO));

  // FIFO model for the main DUT: data appears the cycle after a read
  logic [7:0] mem [0:63];
  int wrPtr = 0;
  int rdPtr = 0;
  int readCount = 0;
  assign ifc.fifoEmpty = (wrPtr == rdPtr);
  always @(posedge clk) begin
    if (ifc.fifoRead && rdPtr != wrPtr) begin
      ifc.fifoData <= mem[rdPtr];
      rdPtr <= rdPtr + 1;
    end
  end
  always @(posedge clk) if (ifc.fifoRead) readCount <= readCount + 1;

  // single-word sources for the parity instances
  logic takenE = 1'b0;
  logic takenO = 1'b0;
  assign ifE.fifoData  = 8'h07;
  assign ifO.fifoData  = 8'h07;
  assign ifE.fifoEmpty = !pArm || takenE;
  assign ifO.fifoEmpty = !pArm || takenO;
  always @(posedge clk) begin
    if (rst) takenE <= 1'b0;
    else if (ifE.fifoRead) takenE <= 1'b1;
  end
  always @(posedge clk) begin
    if (rst) takenO <= 1'b0;
    else if (ifO.fifoRead) takenO <= 1'b1;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wrPtr] = d;
    wrPtr = wrPtr + 1;
  endtask

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task wait_read(input string tag);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ifc.fifoRead === 1'b1) break;
    end
    chk({tag, " fetch seen"}, ifc.fifoRead, 1);
  endtask

  // expected line level at a cycle offset from the fifoRead pulse (CLKS_PER_BIT = 4)
  function automatic logic exp_tx(input logic [7:0] d, input int off, input bit parOn, input logic parBit);
    if (off >= 2 && off < 6) return 1'b0;
    if (off >= 6 && off < 38) return d[(off - 6) / 4];
    if (parOn && off >= 38 && off < 42) return parBit;
    return 1'b1;
  endfunction

  // called in the FETCH cycle of the main DUT; ends in the cycle after the last stop cycle
  task check_frame(input logic [7:0] d, input bit chained, input int dropAt);
    chk($sformatf("frame %0h fetch read", d), ifc.fifoRead, 1);
    chk($sformatf("frame %0h fetch tx", d), txM, 1);
    for (int off = 1; off <= 42; off++) begin
      tick();
      if (off < 42) begin
        chk($sformatf("frame %0h tx off %0d", d, off), txM, exp_tx(d, off, 1'b0, 1'b0));
        chk($sformatf("frame %0h busy off %0d", d, off), busyM, 1);
        chk($sformatf("frame %0h read off %0d", d, off), ifc.fifoRead, 0);
        chk($sformatf("frame %0h count off %0d", d, off), fsM, expFrames);
      end else begin
        expFrames = expFrames + 16'd1;
        chk($sformatf("frame %0h count end", d), fsM, expFrames);
        chk($sformatf("frame %0h busy end", d), busyM, chained);
        chk($sformatf("frame %0h read end", d), ifc.fifoRead, chained);
        chk($sformatf("frame %0h tx end", d), txM, 1);
      end
      if (off == dropAt) enable = 1'b0;
    end
  endtask

  int rc0;

  initial begin
    // reset state
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) tick();
    chk("reset tx", txM, 1);
    chk("reset read", ifc.fifoRead, 0);
    chk("reset busy", busyM, 0);
    chk("reset count", fsM, 0);
    chk("reset state", dsM, 32'(ST_IDLE));
    rst = 1'b0;

    // idle with empty FIFO
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle tx", txM, 1);
      chk("idle read", ifc.fifoRead, 0);
      chk("idle busy", busyM, 0);
      chk("idle count", fsM, 0);
    end

    // single word
    push(8'hA5);
    wait_read("single");
    check_frame(8'hA5, 1'b0, -1);
    tick();
    chk("single idle state", dsM, 32'(ST_IDLE));

    // back-to-back: two fetch cycles of tx high between frames
    rc0 = readCount;
    push(8'h00);
    push(8'hFF);
    wait_read("b2b");
    check_frame(8'h00, 1'b1, -1);
    check_frame(8'hFF, 1'b0, -1);
    repeat (5) tick();
    chk("b2b read pulses", readCount - rc0, 2);

    // reset during DATA bit 3 aborts the word; the next queued word follows
    push(8'h3C);
    push(8'h55);
    wait_read("rst");
    for (int off = 1; off <= 19; off++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expFrames = 16'd0;
    chk("rst tx", txM, 1);
    chk("rst busy", busyM, 0);
    chk("rst count", fsM, 0);
    chk("rst read", ifc.fifoRead, 0);
    tick();
    check_frame(8'h55, 1'b0, -1);

    // enable gating with three words queued
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_read("en");
    check_frame(8'h11, 1'b0, 10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gated read", ifc.fifoRead, 0);
      chk("gated busy", busyM, 0);
    end
    enable = 1'b1;
    tick();
    check_frame(8'h22, 1'b1, -1);
    check_frame(8'h33, 1'b0, -1);

    // parity: 0x07 -> even bit 1, odd bit 0; even instance has two stop bits
    pArm = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ifE.fifoRead === 1'b1) break;
    end
    chk("par even fetch", ifE.fifoRead, 1);
    chk("par odd fetch", ifO.fifoRead, 1);
    for (int off = 1; off <= 50; off++) begin
      tick();
      chk($sformatf("even tx off %0d", off), txE, exp_tx(8'h07, off, 1'b1, 1'b1));
      chk($sformatf("even busy off %0d", off), busyE, (off < 50));
      chk($sformatf("even count off %0d", off), fsE, (off < 50) ? 0 : 1);
      chk($sformatf("odd tx off %0d", off), txO, exp_tx(8'h07, off, 1'b1, 1'b0));
      chk($sformatf("odd busy off %0d", off), busyO, (off < 46));
      chk($sformatf("odd count off %0d", off), fsO, (off < 46) ? 0 : 1);
      chk($sformatf("par read off %0d", off), ifE.fifoRead | ifO.fifoRead, 0);
    end
    pArm = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
